// File: rtl/instruction_queue_pkg.sv
// instruction_queue_pkg: shared record type, sizes and per-copy address expansion
package instruction_queue_pkg;
  localparam int LOG_DEPTH = 4;
  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int ISSUE_WIDTH = 3;
  localparam int ADDR_W = 18;
  localparam int INSTR_W = 16;
  localparam int MAX_COPIES = 8;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [3:0]         copies;
    logic [ADDR_W-1:0]  cache_addr;
    logic [ADDR_W-1:0]  d_cache_addr;
    logic [ADDR_W-1:0]  mem_addr;
    logic [ADDR_W-1:0]  d_mem_addr;
  } iq_record_t;
  function automatic logic [ADDR_W-1:0] expand_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] delta,
                                                    input logic [2:0] k);
    return base + (k[0] ? delta : '0) + (k[1] ? (delta << 1) : '0) + (k[2] ? (delta << 2) : '0);
  endfunction
endpackage

// File: rtl/iq_lane_gen.sv
// iq_lane_gen: walks the head window in program order, one copy per lane, with address expansion
module iq_lane_gen
  import instruction_queue_pkg::*;
(
  input  iq_record_t                   win_i [ISSUE_WIDTH],
  input  logic [LOG_DEPTH:0]           count_i,
  input  logic [2:0]                   idx_i,
  output logic [ISSUE_WIDTH-1:0]       valid_o,
  output logic [ISSUE_WIDTH*INSTR_W-1:0] instr_o,
  output logic [ISSUE_WIDTH*ADDR_W-1:0]  cache_o,
  output logic [ISSUE_WIDTH*ADDR_W-1:0]  mem_o,
  output logic [1:0]                   retire_o,
  output logic [2:0]                   idx_o
);
  logic [1:0] r;
  logic [2:0] i;
  logic       last;
  iq_record_t rec;
  always_comb begin
    r = '0;
    i = idx_i;
    last = 1'b0;
    rec = '0;
    valid_o = '0;
    instr_o = '0;
    cache_o = '0;
    mem_o = '0;
    for (int l = 0; l < ISSUE_WIDTH; l++) begin
      if ((LOG_DEPTH+1)'(r) < count_i) begin
        rec = win_i[r];
        valid_o[l] = 1'b1;
        instr_o[l*INSTR_W +: INSTR_W] = rec.instr;
        cache_o[l*ADDR_W +: ADDR_W] = expand_addr(rec.cache_addr, rec.d_cache_addr, i);
        mem_o[l*ADDR_W +: ADDR_W] = expand_addr(rec.mem_addr, rec.d_mem_addr, i);
        last = {1'b0, i} == rec.copies - 4'd1;
        r = last ? r + 2'd1 : r;
        i = last ? 3'd0 : i + 3'd1;
      end
    end
    retire_o = r;
    idx_o = i;
  end
endmodule

// File: rtl/instruction_queue.sv
// instruction_queue: compressed-record FIFO expanded onto issue lanes; IQUEUE_STATS_EN adds stat_issued/stat_empty_cycles
module instruction_queue
  import instruction_queue_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          push_valid,
  output logic                          push_ready,
  input  logic [INSTR_W-1:0]            push_instr,
  input  logic [3:0]                    push_copies,
  input  logic [ADDR_W-1:0]             push_cache_addr,
  input  logic [ADDR_W-1:0]             push_d_cache_addr,
  input  logic [ADDR_W-1:0]             push_mem_addr,
  input  logic [ADDR_W-1:0]             push_d_mem_addr,
  output logic [ISSUE_WIDTH-1:0]        out_valid,
  output logic [ISSUE_WIDTH*INSTR_W-1:0] out_instr,
  output logic [ISSUE_WIDTH*ADDR_W-1:0]  out_cache_addr,
  output logic [ISSUE_WIDTH*ADDR_W-1:0]  out_mem_addr,
  input  logic                          out_ready
`ifdef IQUEUE_STATS_EN
  ,
  output logic [31:0]                   stat_issued,
  output logic [31:0]                   stat_empty_cycles
`endif
);
  iq_record_t mem_q [DEPTH];
  iq_record_t win [ISSUE_WIDTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LOG_DEPTH:0] count_q;
  logic [2:0] idx_q, lg_idx;
  logic [1:0] lg_retire;
  logic [ISSUE_WIDTH-1:0] lg_valid;
  logic [ISSUE_WIDTH*INSTR_W-1:0] lg_instr;
  logic [ISSUE_WIDTH*ADDR_W-1:0] lg_cache, lg_mem;
  logic push_fire, load;
  logic [3:0] copies;
  assign push_ready = count_q < (LOG_DEPTH+1)'(DEPTH);
  assign push_fire = push_valid && push_ready;
  assign load = out_valid == '0 || out_ready;
  assign copies = push_copies == 4'd0 ? 4'd1 : push_copies > 4'(MAX_COPIES) ? 4'(MAX_COPIES) : push_copies;
  for (genvar j = 0; j < ISSUE_WIDTH; j++) begin : g_win
    assign win[j] = mem_q[rd_ptr_q + LOG_DEPTH'(j)];
  end
  iq_lane_gen u_lane_gen (
    .win_i    (win),
    .count_i  (count_q),
    .idx_i    (idx_q),
    .valid_o  (lg_valid),
    .instr_o  (lg_instr),
    .cache_o  (lg_cache),
    .mem_o    (lg_mem),
    .retire_o (lg_retire),
    .idx_o    (lg_idx)
  );
  always_ff @(posedge clk) begin
    if (push_fire)
      mem_q[wr_ptr_q] <= '{instr: push_instr, copies: copies, cache_addr: push_cache_addr,
                           d_cache_addr: push_d_cache_addr, mem_addr: push_mem_addr,
                           d_mem_addr: push_d_mem_addr};
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      idx_q <= '0;
      out_valid <= '0;
      out_instr <= '0;
      out_cache_addr <= '0;
      out_mem_addr <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + LOG_DEPTH'(push_fire);
      count_q <= count_q + (LOG_DEPTH+1)'(push_fire) - (load ? (LOG_DEPTH+1)'(lg_retire) : '0);
      if (load) begin
        rd_ptr_q <= rd_ptr_q + LOG_DEPTH'(lg_retire);
        idx_q <= lg_idx;
        out_valid <= lg_valid;
        out_instr <= lg_instr;
        out_cache_addr <= lg_cache;
        out_mem_addr <= lg_mem;
      end
    end
  end
`ifdef IQUEUE_STATS_EN
  logic [32:0] issued_sum;
  assign issued_sum = {1'b0, stat_issued} + (out_ready ? 33'($countones(out_valid)) : 33'd0);
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued <= '0;
      stat_empty_cycles <= '0;
    end else begin
      stat_issued <= issued_sum[32] ? '1 : issued_sum[31:0];
      if (count_q == '0 && out_valid == '0 && stat_empty_cycles != '1)
        stat_empty_cycles <= stat_empty_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: scoreboard bench with a copy-list reference model and randomized traffic
module tb_instruction_queue;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic push_valid = 1'b0;
  logic push_ready;
  logic [15:0] push_instr = '0;
  logic [3:0] push_copies = '0;
  logic [17:0] push_cache_addr = '0, push_d_cache_addr = '0, push_mem_addr = '0, push_d_mem_addr = '0;
  logic [2:0] out_valid;
  logic [47:0] out_instr;
  logic [53:0] out_cache_addr, out_mem_addr;
  logic out_ready = 1'b0;
`ifdef IQUEUE_STATS_EN
  logic [31:0] stat_issued, stat_empty_cycles;
`endif
  typedef struct {
    logic [15:0] instr;
    logic [3:0]  copies;
    logic [17:0] c, dc, m, dm;
  } rec_t;
  typedef struct {
    logic [15:0] instr;
    logic [17:0] c, m;
  } lane_t;
  lane_t exp_q[$];
  lane_t mon_e;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  instruction_queue dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .push_valid        (push_valid),
    .push_ready        (push_ready),
    .push_instr        (push_instr),
    .push_copies       (push_copies),
    .push_cache_addr   (push_cache_addr),
    .push_d_cache_addr (push_d_cache_addr),
    .push_mem_addr     (push_mem_addr),
    .push_d_mem_addr   (push_d_mem_addr),
    .out_valid         (out_valid),
    .out_instr         (out_instr),
    .out_cache_addr    (out_cache_addr),
    .out_mem_addr      (out_mem_addr),
    .out_ready         (out_ready)
`ifdef IQUEUE_STATS_EN
    ,
    .stat_issued       (stat_issued),
    .stat_empty_cycles (stat_empty_cycles)
`endif
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  function automatic rec_t mk(input logic [15:0] instr, input logic [3:0] copies,
                              input logic [17:0] c, input logic [17:0] dc,
                              input logic [17:0] m, input logic [17:0] dm);
    rec_t r;
    r.instr = instr;
    r.copies = copies;
    r.c = c;
    r.dc = dc;
    r.m = m;
    r.dm = dm;
    return r;
  endfunction
  function automatic void add_exp(input rec_t r);
    int n = (r.copies == 0) ? 1 : int'(r.copies);
    for (int k = 0; k < n; k++) begin
      lane_t e;
      e.instr = r.instr;
      e.c = 18'((int'(r.c) + k * int'(r.dc)) % 262144);
      e.m = 18'((int'(r.m) + k * int'(r.dm)) % 262144);
      exp_q.push_back(e);
    end
  endfunction
  task automatic step(input logic pv, input rec_t r, input logic ordy, input logic fl, input logic rs);
    push_valid = pv;
    push_instr = r.instr;
    push_copies = r.copies;
    push_cache_addr = r.c;
    push_d_cache_addr = r.dc;
    push_mem_addr = r.m;
    push_d_mem_addr = r.dm;
    out_ready = (fl || rs) ? 1'b0 : ordy;
    flush = fl;
    reset = rs;
    @(negedge clk);
    if (pv && push_ready && !fl && !rs) add_exp(r);
    @(posedge clk);
    #1;
    if (fl || rs) exp_q.delete();
    flush = 1'b0;
    reset = 1'b0;
    push_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid != 3'b000) && n < 400) begin
      step(1'b0, mk(0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0);
      n++;
    end
    check("drain_leftover", 64'(exp_q.size()), 0);
    check("drain_out_valid", 64'(out_valid), 0);
  endtask
  always @(negedge clk) begin
    if (!reset && out_valid != 3'b000) begin
      check("contiguous", 64'(out_valid == 3'b001 || out_valid == 3'b011 || out_valid == 3'b111), 1);
      if (out_ready) begin
        for (int l = 0; l < 3; l++) begin
          if (out_valid[l]) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL underflow: lane %0d instr %0h issued, expected no lane", l, out_instr[l*16 +: 16]);
            end else begin
              mon_e = exp_q.pop_front();
              check("lane_instr", 64'(out_instr[l*16 +: 16]), 64'(mon_e.instr));
              check("lane_cache", 64'(out_cache_addr[l*18 +: 18]), 64'(mon_e.c));
              check("lane_mem", 64'(out_mem_addr[l*18 +: 18]), 64'(mon_e.m));
            end
          end
        end
      end
    end
  end
  initial begin
    rec_t idle;
    int acc, pops;
    logic [2:0] hv;
    logic [47:0] hi;
`ifdef IQUEUE_STATS_EN
    logic [31:0] saved_issued;
`endif
    idle = mk(0, 0, 0, 0, 0, 0);
    step(1'b0, idle, 1'b0, 1'b0, 1'b1);
    step(1'b0, idle, 1'b0, 1'b0, 1'b1);
    check("reset_out_valid", 64'(out_valid), 0);
    check("reset_push_ready", 64'(push_ready), 1);
    check("reset_out_instr", 64'(out_instr), 0);
    check("reset_out_cache", 64'(out_cache_addr), 0);
    step(1'b1, mk(16'h8001, 1, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    check("latency_edge_n", 64'(out_valid), 0);
    step(1'b0, idle, 1'b0, 1'b0, 1'b0);
    check("latency_edge_n1", 64'(out_valid), 3'b001);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    check("latency_popped", 64'(out_valid), 0);
    step(1'b1, mk(16'h1234, 8, 18'd100, 18'd4, 18'h200, 18'h10), 1'b1, 1'b0, 1'b0);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    check("copies8_first", 64'(out_valid), 3'b111);
    check("copies8_lane0_cache", 64'(out_cache_addr[17:0]), 100);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    check("copies8_second", 64'(out_valid), 3'b111);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    check("copies8_third", 64'(out_valid), 3'b011);
    check("copies8_last_cache", 64'(out_cache_addr[35:18]), 128);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    check("copies8_empty", 64'(out_valid), 0);
    step(1'b1, mk(16'h0F00, 1, 1, 0, 2, 0), 1'b0, 1'b0, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(16'hA001, 1, 11, 0, 21, 0), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(16'hA002, 0, 12, 0, 22, 0), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(16'hA003, 1, 13, 0, 23, 0), 1'b0, 1'b0, 1'b0);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    check("three_records", 64'(out_valid), 3'b111);
    check("three_records_lane2", 64'(out_instr[47:32]), 16'hA003);
    drain();
    acc = 0;
    while (push_ready && acc < 40) begin
      step(1'b1, mk(16'h4000 + 16'(acc), 8, 18'(acc * 3), 1, 18'(acc), 2), 1'b0, 1'b0, 1'b0);
      acc++;
    end
    check("fill_count", 64'(acc), 16);
    check("fill_push_ready", 64'(push_ready), 0);
    hv = out_valid;
    hi = out_instr;
    step(1'b1, mk(16'hDEAD, 1, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0, 1'b0);
    check("stall_valid_hold", 64'(out_valid), 64'(hv));
    check("stall_instr_hold", 64'(out_instr), 64'(hi));
    pops = 0;
    while (!push_ready && pops < 10) begin
      step(1'b0, idle, 1'b1, 1'b0, 1'b0);
      pops++;
    end
    check("pops_until_ready", 64'(pops), 2);
    drain();
    step(1'b1, mk(16'h5555, 4, 18'h3FFFE, 1, 18'h3FFFF, 18'h3FFFF), 1'b1, 1'b0, 1'b0);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    check("wrap_lane2_cache", 64'(out_cache_addr[53:36]), 0);
    check("wrap_lane2_mem", 64'(out_mem_addr[53:36]), 18'h3FFFD);
    drain();
    step(1'b1, mk(16'h6666, 8, 10, 2, 20, 3), 1'b0, 1'b0, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0, 1'b0);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0, 1'b1);
    check("midreset_out_valid", 64'(out_valid), 0);
    check("midreset_push_ready", 64'(push_ready), 1);
    check("midreset_out_instr", 64'(out_instr), 0);
    step(1'b1, mk(16'h7777, 2, 5, 5, 6, 6), 1'b0, 1'b0, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0, 1'b0);
    check("after_reset_valid", 64'(out_valid), 3'b011);
    check("after_reset_instr", 64'(out_instr[15:0]), 16'h7777);
    drain();
`ifdef IQUEUE_STATS_EN
    saved_issued = stat_issued;
`endif
    step(1'b1, mk(16'h6161, 8, 1, 1, 1, 1), 1'b0, 1'b0, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(16'hF1F1, 1, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0);
    check("flush_out_valid", 64'(out_valid), 0);
`ifdef IQUEUE_STATS_EN
    check("flush_keeps_stat", 64'(stat_issued), 64'(saved_issued));
`endif
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    check("flush_dropped_push", 64'(out_valid), 0);
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 2) != 0,
           mk(16'($urandom), 4'($urandom_range(0, 8)), 18'($urandom), 18'($urandom),
              18'($urandom), 18'($urandom)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0, 1'b0);
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
